interrupt_injector: RTL and testbench
=====================================

INTERRUPT_INJECTOR -- requirements
Module: interrupt_injector

Interface
REQ-001 SHALL have parameter DEPTH, default 4: interrupt FIFO entries, power of two, range 2..16.
REQ-002 SHALL have parameter HOLDOFF_CYC, default 2: idle cycles enforced after each delivered interrupt, range 0..15.
REQ-003 SHALL have parameter OVF_W, default 8: width of the overflow counter.
REQ-004 SHALL have port proc_clk, input, 1: the single processor clock; all state is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port interrupt_instruction, input, 32: interrupt word from the input controller; 32'b0 means none; a nonzero value is a one-cycle request.
REQ-007 SHALL have port inject_ready, input, 1: the processor fetch stage can accept an injected instruction this cycle.
REQ-008 SHALL have port inject_valid, output, 1: inject_instruction holds a pending interrupt.
REQ-009 SHALL have port inject_instruction, output, 32: head-of-queue interrupt word; 32'b0 when inject_valid is 0.
REQ-010 SHALL have port pending_count, output, $clog2(DEPTH)+1: number of queued entries, including the presented one.
REQ-011 SHALL have port overflow_count, output, OVF_W: requests dropped because the queue was full; saturates.
REQ-012 SHALL have port busy, output, 1: high when the FSM is not IDLE or pending_count is nonzero.

Function
REQ-013 SHALL enqueue interrupt_instruction on any cycle it is nonzero and the queue is not full; the word is visible on inject_instruction no earlier than the next cycle.
REQ-014 SHALL run an FSM with states IDLE, PRESENT and HOLDOFF.
REQ-015 IDLE: SHALL move to PRESENT on the cycle after pending_count becomes nonzero; inject_valid=0 while in IDLE.
REQ-016 PRESENT: SHALL drive inject_valid=1 with the head word; the word SHALL stay stable until the transfer cycle (inject_valid and inject_ready both high).
REQ-017 On transfer, SHALL pop the head and go to HOLDOFF when HOLDOFF_CYC>0; otherwise go to PRESENT if entries remain, else IDLE.
REQ-018 HOLDOFF: SHALL hold inject_valid=0 for exactly HOLDOFF_CYC cycles, then go to PRESENT if pending_count>0, else IDLE.
REQ-019 Full queue with no pop that cycle: SHALL drop the new request and increment overflow_count, saturating at 2^OVF_W-1.
REQ-020 Full queue with a transfer in the same cycle: SHALL accept the new request; no overflow is counted and the count stays at DEPTH.
REQ-021 Simultaneous push and pop at any fill level: pending_count SHALL stay unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across the wrap.
REQ-023 Enqueued words SHALL NOT be modified; the block SHALL NOT inspect opcodes.

Reset
REQ-024 On reset_n low, SHALL immediately force: FSM=IDLE, inject_valid=0, inject_instruction=0, pending_count=0, overflow_count=0, busy=0, pointers=0, holdoff timer=0.
REQ-025 Reset asserted mid-PRESENT or mid-HOLDOFF SHALL discard all queued entries; no transfer SHALL complete in that cycle.
REQ-026 First enqueue SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-027 With macro INTR_COALESCE_EN defined, a request equal to the most recently enqueued entry that is still queued and not the presented head SHALL be discarded silently; it does not count as overflow.
REQ-028 Without INTR_COALESCE_EN, every nonzero request SHALL be enqueued or counted as overflow.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/PRESENT/HOLDOFF), the 32-bit instruction word typedef and the NO_INTERRUPT=32'b0 constant.
REQ-030 Storage SHALL be one sub-module, intr_fifo: push, pop, full, empty, count, head data; parameterised by DEPTH.

Verification
REQ-031 Single request 32'hA000_0001 with inject_ready=1 -> inject_valid high one cycle later for exactly 1 cycle, then 2 cycles low; busy returns to 0.
REQ-032 Five requests back-to-back with inject_ready=0, DEPTH=4 -> pending_count=4, overflow_count=1; drain order matches the first four words.
REQ-033 Queue full, inject_ready=1 in the transfer cycle with a new request arriving -> accepted, overflow_count unchanged, pending_count stays 4.
REQ-034 reset_n pulsed low during PRESENT with 3 entries queued -> all outputs 0 asynchronously; no inject_valid after release until a new request.
REQ-035 With INTR_COALESCE_EN, requests 32'h1, 32'h2, 32'h2 while the head is stalled -> pending_count=2, overflow_count=0; without the macro -> pending_count=3.
REQ-036 300 forced overflows with OVF_W=8 -> overflow_count saturates at 255.

Source files
------------

// File: rtl/interrupt_injector_pkg.sv
// Shared types and constants for the interrupt injector: FSM state encoding,
// the 32-bit instruction word and the "no interrupt" marker.
package interrupt_injector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    typedef logic [31:0] instr_t;

    localparam instr_t NO_INTERRUPT = 32'b0;

    // Wide enough for holdoff counts up to 15.
    localparam int HOLD_W = 4;

endpackage

// File: rtl/interrupt_injector_intr_fifo.sv
// Interrupt word FIFO: DEPTH entries (power of two), pointers wrap naturally.
// A push is honoured on a full queue only when a pop frees the head slot that cycle.
module intr_fifo
    import interrupt_injector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     proc_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  instr_t                   push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output instr_t                   head_data,
    output instr_t                   tail_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    instr_t          mem_q [DEPTH];
    instr_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign tail_data = mem_q[wr_ptr_q - AW'(1)];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge proc_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NO_INTERRUPT;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/interrupt_injector.sv
// Queues interrupt words and injects them into the fetch stage with a holdoff gap.
// Optional macro INTR_COALESCE_EN drops a request equal to the newest queued, unpresented entry.
//
//   state   | meaning
//   IDLE    | nothing presented; waits for a queued entry
//   PRESENT | head word on inject_instruction, waits for inject_ready
//   HOLDOFF | enforced idle gap after a transfer, HOLDOFF_CYC cycles
module interrupt_injector
    import interrupt_injector_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLDOFF_CYC = 2,
    parameter int OVF_W       = 8
) (
    input  logic                     proc_clk,
    input  logic                     reset_n,
    input  logic [31:0]              interrupt_instruction,
    input  logic                     inject_ready,
    output logic                     inject_valid,
    output logic [31:0]              inject_instruction,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic [OVF_W-1:0]         overflow_count,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;

    logic                req, coalesce, xfer, push, drop;
    logic                full, empty;
    logic [CW-1:0]       count;
    instr_t              head, tail;

    assign req  = (interrupt_instruction != NO_INTERRUPT);
    assign xfer = (state_q == PRESENT) && inject_ready;

`ifdef INTR_COALESCE_EN
    // A lone entry that is currently presented is the head, so it never coalesces.
    assign coalesce = req && !empty && (tail == interrupt_instruction)
                      && !((state_q == PRESENT) && (count == CW'(1)));
`else
    logic unused_tail;
    assign unused_tail = ^tail;
    assign coalesce    = 1'b0;
`endif

    assign push = req && !coalesce && (!full || xfer);
    assign drop = req && !coalesce && full && !xfer;

    intr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .proc_clk  (proc_clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (xfer),
        .push_data (interrupt_instruction),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_data (head),
        .tail_data (tail)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (xfer) begin
                    if (HOLDOFF_CYC > 0) begin
                        state_d = HOLDOFF;
                        hold_d  = HOLD_W'(HOLDOFF_CYC - 1);
                    end else if ((count > CW'(1)) || push) begin
                        state_d = PRESENT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = empty ? IDLE : PRESENT;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge proc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    assign inject_valid       = (state_q == PRESENT);
    assign inject_instruction = inject_valid ? head : NO_INTERRUPT;
    assign pending_count      = count;
    assign overflow_count     = ovf_q;
    assign busy               = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_interrupt_injector.sv
// Directed self-checking bench for interrupt_injector (DEPTH=4, HOLDOFF_CYC=2, OVF_W=8).
module tb_interrupt_injector;

    logic        proc_clk;
    logic        reset_n;
    logic [31:0] interrupt_instruction;
    logic        inject_ready;
    logic        inject_valid;
    logic [31:0] inject_instruction;
    logic [2:0]  pending_count;
    logic [7:0]  overflow_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    interrupt_injector #(
        .DEPTH       (4),
        .HOLDOFF_CYC (2),
        .OVF_W       (8)
    ) dut (
        .proc_clk              (proc_clk),
        .reset_n               (reset_n),
        .interrupt_instruction (interrupt_instruction),
        .inject_ready          (inject_ready),
        .inject_valid          (inject_valid),
        .inject_instruction    (inject_instruction),
        .pending_count         (pending_count),
        .overflow_count        (overflow_count),
        .busy                  (busy)
    );

    initial proc_clk = 1'b0;
    always #5 proc_clk = ~proc_clk;

    task automatic do_reset();
        reset_n               = 1'b0;
        interrupt_instruction = 32'h0;
        inject_ready          = 1'b0;
        @(negedge proc_clk);
        @(negedge proc_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n               = 1'b0;
        interrupt_instruction = 32'h0;
        inject_ready          = 1'b0;
        @(negedge proc_clk);
        checks++; if (inject_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", inject_valid); end
        checks++; if (inject_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", inject_instruction); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL reset_pending: got %0d expected 0", pending_count); end
        checks++; if (overflow_count !== 8'd0) begin failures++; $display("FAIL reset_ovf: got %0d expected 0", overflow_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge proc_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic exp_valid [5];
        logic exp_busy  [5];
        exp_valid[0] = 1'b0; exp_busy[0] = 1'b1;
        exp_valid[1] = 1'b1; exp_busy[1] = 1'b1;
        exp_valid[2] = 1'b0; exp_busy[2] = 1'b1;
        exp_valid[3] = 1'b0; exp_busy[3] = 1'b1;
        exp_valid[4] = 1'b0; exp_busy[4] = 1'b0;
        inject_ready          = 1'b1;
        interrupt_instruction = 32'hA000_0001;
        @(negedge proc_clk);
        interrupt_instruction = 32'h0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (inject_valid !== exp_valid[c]) begin
                failures++; $display("FAIL single_valid c%0d: got %b expected %b", c, inject_valid, exp_valid[c]);
            end
            checks++;
            if (busy !== exp_busy[c]) begin
                failures++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, exp_busy[c]);
            end
            if (c == 1) begin
                checks++;
                if (inject_instruction !== 32'hA000_0001) begin
                    failures++; $display("FAIL single_word: got %h expected a0000001", inject_instruction);
                end
            end
            @(negedge proc_clk);
        end
    endtask

    task automatic test_overflow_drain();
        logic [31:0] w [5];
        int idx;
        for (int i = 0; i < 5; i++) w[i] = 32'h1111_0001 + i;
        do_reset();
        inject_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            interrupt_instruction = w[i];
            @(negedge proc_clk);
        end
        interrupt_instruction = 32'h0;
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL ovf_pending: got %0d expected 4", pending_count); end
        checks++; if (overflow_count !== 8'd1) begin failures++; $display("FAIL ovf_count: got %0d expected 1", overflow_count); end
        inject_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (inject_valid) begin
                if (idx < 4) begin
                    checks++;
                    if (inject_instruction !== w[idx]) begin
                        failures++; $display("FAIL drain_order %0d: got %h expected %h", idx, inject_instruction, w[idx]);
                    end
                end
                idx++;
            end
            @(negedge proc_clk);
        end
        checks++; if (idx !== 4) begin failures++; $display("FAIL drain_count: got %0d expected 4", idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_transfer_push();
        logic [31:0] w [5];
        int idx;
        for (int i = 0; i < 5; i++) w[i] = 32'h2222_0010 + i;
        do_reset();
        inject_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            interrupt_instruction = w[i];
            @(negedge proc_clk);
        end
        checks++; if (inject_instruction !== w[0]) begin failures++; $display("FAIL full_head: got %h expected %h", inject_instruction, w[0]); end
        interrupt_instruction = w[4];
        inject_ready          = 1'b1;
        @(negedge proc_clk);
        interrupt_instruction = 32'h0;
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL full_xfer_pending: got %0d expected 4", pending_count); end
        checks++; if (overflow_count !== 8'd0) begin failures++; $display("FAIL full_xfer_ovf: got %0d expected 0", overflow_count); end
        idx = 1;
        for (int c = 0; c < 40; c++) begin
            if (inject_valid) begin
                if (idx < 5) begin
                    checks++;
                    if (inject_instruction !== w[idx]) begin
                        failures++; $display("FAIL wrap_order %0d: got %h expected %h", idx, inject_instruction, w[idx]);
                    end
                end
                idx++;
            end
            @(negedge proc_clk);
        end
        checks++; if (idx !== 5) begin failures++; $display("FAIL wrap_count: got %0d expected 5", idx); end
    endtask

    task automatic test_reset_mid_present();
        int seen;
        do_reset();
        inject_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            interrupt_instruction = 32'h3333_0001 + i;
            @(negedge proc_clk);
        end
        interrupt_instruction = 32'h0;
        checks++; if (inject_valid !== 1'b1) begin failures++; $display("FAIL mid_present: got %b expected 1", inject_valid); end
        #2;
        inject_ready = 1'b1;
        reset_n      = 1'b0;
        #1;
        checks++; if (inject_valid !== 1'b0) begin failures++; $display("FAIL async_valid: got %b expected 0", inject_valid); end
        checks++; if (inject_instruction !== 32'h0) begin failures++; $display("FAIL async_instr: got %h expected 0", inject_instruction); end
        checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL async_pending: got %0d expected 0", pending_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %b expected 0", busy); end
        @(negedge proc_clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge proc_clk);
            if (inject_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL post_reset_valid: got %0d expected 0", seen); end
        interrupt_instruction = 32'h3333_00AA;
        @(negedge proc_clk);
        interrupt_instruction = 32'h0;
        @(negedge proc_clk);
        checks++; if (inject_instruction !== 32'h3333_00AA) begin failures++; $display("FAIL post_reset_new: got %h expected 333300aa", inject_instruction); end
    endtask

    task automatic test_coalesce();
        logic [2:0] exp_pend;
`ifdef INTR_COALESCE_EN
        exp_pend = 3'd2;
`else
        exp_pend = 3'd3;
`endif
        do_reset();
        inject_ready = 1'b0;
        interrupt_instruction = 32'h1; @(negedge proc_clk);
        interrupt_instruction = 32'h2; @(negedge proc_clk);
        interrupt_instruction = 32'h2; @(negedge proc_clk);
        interrupt_instruction = 32'h0;
        checks++; if (pending_count !== exp_pend) begin failures++; $display("FAIL coalesce_pending: got %0d expected %0d", pending_count, exp_pend); end
        checks++; if (overflow_count !== 8'd0) begin failures++; $display("FAIL coalesce_ovf: got %0d expected 0", overflow_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        inject_ready = 1'b0;
        for (int i = 0; i < 304; i++) begin
            interrupt_instruction = 32'h0000_0001 + i;
            @(negedge proc_clk);
            if (i == 257) begin
                checks++; if (overflow_count !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d expected 254", overflow_count); end
            end
            if (i == 258) begin
                checks++; if (overflow_count !== 8'd255) begin failures++; $display("FAIL sat_255: got %0d expected 255", overflow_count); end
            end
        end
        interrupt_instruction = 32'h0;
        checks++; if (overflow_count !== 8'd255) begin failures++; $display("FAIL sat_final: got %0d expected 255", overflow_count); end
        checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL sat_pending: got %0d expected 4", pending_count); end
    endtask

    initial begin
        reset_n               = 1'b0;
        interrupt_instruction = 32'h0;
        inject_ready          = 1'b0;
        test_reset();
        test_single();
        test_overflow_drain();
        test_full_transfer_push();
        test_reset_mid_present();
        test_coalesce();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
